fft_seq_ctrl: RTL and testbench

FFT_SEQ_CTRL -- requirements
Module: fft_seq_ctrl

---
 rtl/fft_pkg.sv | 19 +
 rtl/fft_frame_buf.sv | 33 +++
 rtl/fft_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_fft_seq_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants, FSM state type and the index bit-reverse helper for the
// 16-point FFT sequencer.
package fft_pkg;

    localparam int NPOINT = 16;
    localparam int NSTAGE = 4;
    localparam int DW     = 32;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_CALC  = 2'd1,
        ST_DRAIN = 2'd2
    } fft_state_t;

    function automatic logic [3:0] bitrev4(input logic [3:0] idx);
        return {idx[0], idx[1], idx[2], idx[3]};
    endfunction

endpackage

// File: rtl/fft_frame_buf.sv
// 16-word frame register bank: one word written per sample on fill, whole
// frame reloaded from the butterfly datapath once per stage.
module fft_frame_buf #(
    parameter int DW     = fft_pkg::DW,
    parameter int NPOINT = fft_pkg::NPOINT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [3:0]             wr_idx,
    input  logic [DW-1:0]          wr_data,
    input  logic                   ld_en,
    input  logic [NPOINT*DW-1:0]   ld_data,
    output logic [NPOINT*DW-1:0]   frame
);

    logic [NPOINT*DW-1:0] frame_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= '0;
        end else if (ld_en) begin
            frame_q <= ld_data;
        end else if (wr_en) begin
            for (int k = 0; k < NPOINT; k++) begin
                if (wr_idx == 4'(k)) frame_q[k*DW +: DW] <= wr_data;
            end
        end
    end

    assign frame = frame_q;

endmodule

// File: rtl/fft_seq_ctrl.sv
// 16-point FFT sequencer: fills the frame buffer, steps the external butterfly
// datapath through 4 stages, then drains the spectrum. FFT_BITREV_EN selects
// bit-reversed (natural frequency order) readout.
//
// state    | meaning
// ST_FILL  | accepting 16 input samples into the buffer
// ST_CALC  | 4 cycles, buffer reloaded from dp_out for stage 0..3
// ST_DRAIN | presenting 16 output samples with valid/ready handshake
module fft_seq_ctrl #(
    parameter int DW     = fft_pkg::DW,
    parameter int NPOINT = fft_pkg::NPOINT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [DW-1:0]          in_data,
    output logic                   in_ready,
    output logic [NPOINT*DW-1:0]   dp_in,
    input  logic [NPOINT*DW-1:0]   dp_out,
    output logic [1:0]             stage_sel,
    output logic                   out_valid,
    output logic [DW-1:0]          out_data,
    input  logic                   out_ready,
    output logic                   frame_done
);

    import fft_pkg::*;

    fft_state_t state_q, state_d;
    logic [3:0] wr_idx_q, wr_idx_d;
    logic [3:0] rd_idx_q, rd_idx_d;
    logic [1:0] stage_cnt_q, stage_cnt_d;
    logic       frame_done_q, frame_done_d;
    logic       wr_en, ld_en;
    logic [3:0] rd_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FILL;
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            stage_cnt_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_idx_q     <= wr_idx_d;
            rd_idx_q     <= rd_idx_d;
            stage_cnt_q  <= stage_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_idx_d     = wr_idx_q;
        rd_idx_d     = rd_idx_q;
        stage_cnt_d  = stage_cnt_q;
        frame_done_d = 1'b0;
        wr_en        = 1'b0;
        ld_en        = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        stage_sel    = 2'd0;
        unique case (state_q)
            ST_FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_en    = 1'b1;
                    wr_idx_d = wr_idx_q + 4'd1;
                    if (wr_idx_q == 4'(NPOINT - 1)) begin
                        state_d     = ST_CALC;
                        stage_cnt_d = '0;
                    end
                end
            end
            ST_CALC: begin
                stage_sel   = stage_cnt_q;
                ld_en       = 1'b1;
                stage_cnt_d = stage_cnt_q + 2'd1;
                if (stage_cnt_q == 2'(NSTAGE - 1)) begin
                    state_d  = ST_DRAIN;
                    rd_idx_d = '0;
                end
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    rd_idx_d = rd_idx_q + 4'd1;
                    if (rd_idx_q == 4'(NPOINT - 1)) begin
                        frame_done_d = 1'b1;
                        state_d      = ST_FILL;
                    end
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

`ifdef FFT_BITREV_EN
    assign rd_sel = bitrev4(rd_idx_q);
`else
    assign rd_sel = rd_idx_q;
`endif

    // Output word is a pure mux of the buffer, so it holds while stalled.
    always_comb begin
        out_data = '0;
        if (state_q == ST_DRAIN) begin
            for (int k = 0; k < NPOINT; k++) begin
                if (rd_sel == 4'(k)) out_data = dp_in[k*DW +: DW];
            end
        end
    end

    assign frame_done = frame_done_q;

    fft_frame_buf #(
        .DW     (DW),
        .NPOINT (NPOINT)
    ) u_frame_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx_q),
        .wr_data (in_data),
        .ld_en   (ld_en),
        .ld_data (dp_out),
        .frame   (dp_in)
    );

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Directed bench for fft_seq_ctrl with a loopback or radix-2 DIF datapath stub.
module tb_fft_seq_ctrl;

    localparam int DW     = 32;
    localparam int NPOINT = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic [DW-1:0]        in_data;
    logic                 in_ready;
    logic [NPOINT*DW-1:0] dp_in;
    logic [NPOINT*DW-1:0] dp_out;
    logic [1:0]           stage_sel;
    logic                 out_valid;
    logic [DW-1:0]        out_data;
    logic                 out_ready;
    logic                 frame_done;

    logic                 dp_real;
    logic [DW-1:0]        stim [NPOINT];
    logic [DW-1:0]        expv [NPOINT];
    int                   ord  [NPOINT];
    int                   n_cmp = 0;
    int                   n_err = 0;

    always #5 clk = ~clk;

    fft_seq_ctrl #(.DW(DW), .NPOINT(NPOINT)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .dp_in      (dp_in),
        .dp_out     (dp_out),
        .stage_sel  (stage_sel),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .frame_done (frame_done)
    );

    // One DIF radix-2 stage; twiddle W16^k in Q15, k=0 passes through exactly.
    function automatic logic [NPOINT*DW-1:0] fft_stage(input logic [NPOINT*DW-1:0] x,
                                                       input logic [1:0] s);
        int cos_t [8] = '{32767, 30274, 23170, 12540, 0, -12540, -23170, -30274};
        int sin_t [8] = '{0, 12540, 23170, 30274, 32767, 30274, 23170, 12540};
        logic [NPOINT*DW-1:0] y;
        int span, j, tw, ar, ai, br, bi, dr, di, wr, wi, pr, pi;
        y = x;
        span = 8 >> s;
        for (int i = 0; i < NPOINT; i++) begin
            if ((i & span) == 0) begin
                ar = int'($signed(x[i*DW+16 +: 16]));
                ai = int'($signed(x[i*DW +: 16]));
                br = int'($signed(x[(i+span)*DW+16 +: 16]));
                bi = int'($signed(x[(i+span)*DW +: 16]));
                dr = ar - br;
                di = ai - bi;
                j  = i & (span - 1);
                tw = j << s;
                if (tw == 0) begin
                    pr = dr;
                    pi = di;
                end else begin
                    wr = cos_t[tw];
                    wi = -sin_t[tw];
                    pr = (dr * wr - di * wi) >>> 15;
                    pi = (dr * wi + di * wr) >>> 15;
                end
                y[i*DW +: DW]        = {16'(ar + br), 16'(ai + bi)};
                y[(i+span)*DW +: DW] = {16'(pr), 16'(pi)};
            end
        end
        return y;
    endfunction

    always_comb dp_out = dp_real ? fft_stage(dp_in, stage_sel) : dp_in;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Fill, compute and drain one frame. rst_stage>=0 aborts with reset at that CALC cycle.
    task automatic run_frame(input bit hold_valid, input int stall_at, input int rst_stage);
        for (int k = 0; k < NPOINT; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = stim[k];
            chk("fill_in_ready", 64'(in_ready), 64'd1);
        end
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            in_valid = hold_valid;
            in_data  = 32'hDEAD_BEEF;
            chk("calc_stage_sel", 64'(stage_sel), 64'(s));
            chk("calc_in_ready", 64'(in_ready), 64'd0);
            chk("calc_out_valid", 64'(out_valid), 64'd0);
            if (!dp_real && s == 3) begin
                for (int k = 0; k < NPOINT; k++)
                    chk("calc_buf_word", 64'(dp_in[k*DW +: DW]), 64'(stim[k]));
            end
            if (s == rst_stage) begin
                rst      = 1'b1;
                in_valid = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                chk("abort_in_ready", 64'(in_ready), 64'd1);
                chk("abort_out_valid", 64'(out_valid), 64'd0);
                chk("abort_frame_done", 64'(frame_done), 64'd0);
                chk("abort_stage_sel", 64'(stage_sel), 64'd0);
                chk("abort_buf_cleared", 64'(dp_in[0 +: DW]), 64'd0);
                @(negedge clk);
                chk("abort_no_done", 64'(frame_done), 64'd0);
                return;
            end
        end
        for (int n = 0; n < NPOINT; n++) begin
            @(negedge clk);
            in_valid  = hold_valid;
            out_ready = 1'b1;
            if (n == stall_at) begin
                out_ready = 1'b0;
                for (int w = 0; w < 3; w++) begin
                    chk("stall_out_valid", 64'(out_valid), 64'd1);
                    chk("stall_out_data", 64'(out_data), 64'(expv[n]));
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
            chk("drain_out_valid", 64'(out_valid), 64'd1);
            chk("drain_in_ready", 64'(in_ready), 64'd0);
            chk("drain_out_data", 64'(out_data), 64'(expv[n]));
            chk("drain_no_done", 64'(frame_done), 64'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("frame_done_pulse", 64'(frame_done), 64'd1);
        chk("post_out_valid", 64'(out_valid), 64'd0);
        chk("post_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        chk("frame_done_clear", 64'(frame_done), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef FFT_BITREV_EN
        ord = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
`else
        ord = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
`endif
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        dp_real   = 1'b0;

        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_stage_sel", 64'(stage_sel), 64'd0);
        chk("rst_buf", 64'(dp_in[15*DW +: DW]), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_in_ready", 64'(in_ready), 64'd1);

        // Loopback ramp, in_valid held through CALC/DRAIN, stall at rd_idx 5.
        for (int k = 0; k < NPOINT; k++) stim[k] = 32'(k);
        for (int n = 0; n < NPOINT; n++) expv[n] = 32'(ord[n]);
        run_frame(1'b1, 5, -1);

        // Abort at the second CALC cycle, then a fresh frame with other data.
        for (int k = 0; k < NPOINT; k++) stim[k] = 32'hA500_0000 | 32'(k << 8) | 32'(15 - k);
        run_frame(1'b0, -1, 1);
        for (int n = 0; n < NPOINT; n++) expv[n] = stim[ord[n]];
        run_frame(1'b0, -1, -1);

        // Real datapath: impulse gives a flat spectrum.
        dp_real = 1'b1;
        for (int k = 0; k < NPOINT; k++) stim[k] = (k == 0) ? 32'h0001_0000 : 32'h0;
        for (int n = 0; n < NPOINT; n++) expv[n] = 32'h0001_0000;
        run_frame(1'b0, -1, -1);

        // Real datapath: DC input lands entirely in bin 0 (buffer word 0).
        for (int k = 0; k < NPOINT; k++) stim[k] = 32'h0001_0000;
        for (int n = 0; n < NPOINT; n++) expv[n] = (n == 0) ? 32'h0010_0000 : 32'h0;
        run_frame(1'b0, 9, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
